// File: rtl/zpu_wb_pkg.sv
// Shared definitions for the ZPU Wishbone GPIO block: register word offsets,
// bus FSM encoding, counter widths and a byte-lane mask helper.
package zpu_wb_pkg;

  localparam int GPIO_MAX_W  = 32;
  localparam int ACK_LAT_MAX = 4;
  localparam int SYNC_MAX    = 3;
  localparam int LAT_CNT_W   = $clog2(ACK_LAT_MAX);
  localparam int SUPP_CNT_W  = $clog2(SYNC_MAX + 2);

  // Word index taken from wb_adr[4:2]
  localparam logic [2:0] REG_DATA    = 3'd0;
  localparam logic [2:0] REG_DIR     = 3'd1;
  localparam logic [2:0] REG_SET     = 3'd2;
  localparam logic [2:0] REG_CLR     = 3'd3;
  localparam logic [2:0] REG_RISE_EN = 3'd4;
  localparam logic [2:0] REG_FALL_EN = 3'd5;
  localparam logic [2:0] REG_PEND    = 3'd6;
  localparam logic [2:0] REG_RSVD    = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } wb_state_e;

  function automatic logic [GPIO_MAX_W-1:0] lane_mask(input logic [3:0] sel);
    logic [GPIO_MAX_W-1:0] m;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{sel[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/zpu_gpio_sync.sv
// Multi-stage input synchroniser with rise/fall detection on the synchronised
// value; edges are masked for a short window after reset release.
module zpu_gpio_sync
  import zpu_wb_pkg::*;
#(
  parameter int GPIO_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [GPIO_W-1:0] pin_i,
  output logic [GPIO_W-1:0] sync_o,
  output logic [GPIO_W-1:0] rise_o,
  output logic [GPIO_W-1:0] fall_o
);

  logic [SYNC_STAGES-1:0][GPIO_W-1:0] sync_q, sync_d;
  logic [GPIO_W-1:0]                  prev_q, prev_d;
  logic [SUPP_CNT_W-1:0]              supp_q, supp_d;
  logic                               edge_en;

  always_comb begin
    sync_d[0] = pin_i;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
    prev_d = sync_q[SYNC_STAGES-1];
    supp_d = (supp_q != '0) ? supp_q - 1'b1 : supp_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= '0;
      supp_q <= SUPP_CNT_W'(SYNC_STAGES + 1);
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      supp_q <= supp_d;
    end
  end

  // The all-zero reset state of the chain would otherwise fake edges on
  // pins that sit high while reset is released.
  assign edge_en = (supp_q == '0);
  assign sync_o  = sync_q[SYNC_STAGES-1];
  assign rise_o  = sync_o & ~prev_q & {GPIO_W{edge_en}};
  assign fall_o  = ~sync_o & prev_q & {GPIO_W{edge_en}};

endmodule

// File: rtl/zpu_wb_gpio.sv
// Wishbone GPIO peripheral with fixed-latency ack, byte-lane writes,
// set/clear aliases and edge-triggered write-1-to-clear interrupt pending bits.
module zpu_wb_gpio
  import zpu_wb_pkg::*;
#(
  parameter int GPIO_W      = 32,
  parameter int ACK_LAT     = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       wb_adr,
  input  logic [31:0]       wb_in,
  output logic [31:0]       wb_out,
  input  logic [3:0]        wb_sel,
  input  logic              wb_we,
  input  logic              wb_cyc,
  input  logic              wb_stb,
  output logic              wb_ack,
  output logic              wb_stall,
  input  logic [GPIO_W-1:0] gpioin,
  output logic [GPIO_W-1:0] gpioout,
  output logic [GPIO_W-1:0] gpiodir,
  output logic              irq
);

  // Handshake: a request is taken on a rising edge with wb_cyc & wb_stb & !wb_stall;
  // wb_ack is a one-cycle pulse, and dropping wb_cyc before it aborts the request.

  wb_state_e             state_q, state_d;
  logic [LAT_CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]            adr_q, adr_d;
  logic [GPIO_W-1:0]     wdat_q, wdat_d;
  logic [GPIO_W-1:0]     mask_q, mask_d;
  logic                  we_q, we_d;
  logic [31:0]           rdata_q, rdata_d;

  logic [GPIO_W-1:0]     out_q, out_d;
  logic [GPIO_W-1:0]     dir_q, dir_d;
  logic [GPIO_W-1:0]     rise_en_q, rise_en_d;
  logic [GPIO_W-1:0]     fall_en_q, fall_en_d;
  logic [GPIO_W-1:0]     pend_q, pend_d;
  logic                  irq_q, irq_d;

  logic [GPIO_W-1:0]     pin_sync, pin_rise, pin_fall;
  logic [GPIO_W-1:0]     rd_val, wbits, edge_hit;
  logic [GPIO_MAX_W-1:0] mask_full;
  logic [31:0]           rd_word;
  logic                  accept, commit;
  logic                  unused_adr;

  assign unused_adr = ^{wb_adr[31:5], wb_adr[1:0]};

  zpu_gpio_sync #(
    .GPIO_W      (GPIO_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .pin_i  (gpioin),
    .sync_o (pin_sync),
    .rise_o (pin_rise),
    .fall_o (pin_fall)
  );

  assign accept = (state_q == ST_IDLE) && wb_cyc && wb_stb;
  assign commit = (state_q == ST_ACK) && wb_cyc && we_q;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (accept) begin
          state_d = (ACK_LAT == 1) ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!wb_cyc) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == LAT_CNT_W'(ACK_LAT - 1)) begin
            state_d = ST_ACK;
          end
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM: outputs
  always_comb begin
    wb_stall = (state_q != ST_IDLE);
    wb_ack   = (state_q == ST_ACK) && wb_cyc;
    wb_out   = wb_ack ? rdata_q : 32'h0;
  end

  // Read mux on the live address; sampled into rdata_q at acceptance.
  always_comb begin
    rd_val = '0;
    case (wb_adr[4:2])
      REG_DATA:    rd_val = (out_q & dir_q) | (pin_sync & ~dir_q);
      REG_DIR:     rd_val = dir_q;
      REG_SET:     rd_val = '0;
      REG_CLR:     rd_val = '0;
      REG_RISE_EN: rd_val = rise_en_q;
      REG_FALL_EN: rd_val = fall_en_q;
      REG_PEND:    rd_val = pend_q;
      REG_RSVD:    rd_val = '0;
      default:     rd_val = '0;
    endcase
    rd_word = '0;
    rd_word[GPIO_W-1:0] = rd_val;
  end

  assign mask_full = lane_mask(wb_sel);

  always_comb begin
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    mask_d  = mask_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    if (accept) begin
      adr_d   = wb_adr[4:2];
      wdat_d  = wb_in[GPIO_W-1:0];
      mask_d  = mask_full[GPIO_W-1:0];
      we_d    = wb_we;
      rdata_d = wb_we ? 32'h0 : rd_word;
    end
  end

  assign wbits    = wdat_q & mask_q;
  assign edge_hit = (pin_rise & rise_en_q) | (pin_fall & fall_en_q);

  // Edges are OR-ed in after the W1C so a coincident edge wins.
  always_comb begin
    out_d     = out_q;
    dir_d     = dir_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    pend_d    = pend_q;
    if (commit) begin
      case (adr_q)
        REG_DATA:    out_d     = (out_q & ~mask_q) | wbits;
        REG_DIR:     dir_d     = (dir_q & ~mask_q) | wbits;
        REG_SET:     out_d     = out_q | wbits;
        REG_CLR:     out_d     = out_q & ~wbits;
        REG_RISE_EN: rise_en_d = (rise_en_q & ~mask_q) | wbits;
        REG_FALL_EN: fall_en_d = (fall_en_q & ~mask_q) | wbits;
        REG_PEND:    pend_d    = pend_q & ~wbits;
        default:     ;
      endcase
    end
    pend_d = pend_d | edge_hit;
    irq_d  = |pend_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      adr_q     <= '0;
      wdat_q    <= '0;
      mask_q    <= '0;
      we_q      <= 1'b0;
      rdata_q   <= '0;
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      pend_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      adr_q     <= adr_d;
      wdat_q    <= wdat_d;
      mask_q    <= mask_d;
      we_q      <= we_d;
      rdata_q   <= rdata_d;
      out_q     <= out_d;
      dir_q     <= dir_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      pend_q    <= pend_d;
      irq_q     <= irq_d;
    end
  end

  assign gpioout = out_q;
  assign gpiodir = dir_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_zpu_wb_gpio.sv
// Bench for zpu_wb_gpio: three instances (1-cycle/32-bit, 3-cycle/32-bit,
// 4-cycle/8-bit/3-stage sync) exercised by per-feature tasks with a read scoreboard.
module tb_zpu_wb_gpio;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        cyc[3], stb[3], we[3], ack[3], stall[3], irq[3];
  logic [31:0] adr[3], din[3], dout[3];
  logic [3:0]  sel[3];
  logic [31:0] gin0, gin1, gout0, gout1, gdir0, gdir1;
  logic [7:0]  gin2, gout2, gdir2;

  logic [31:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  zpu_wb_gpio #(.GPIO_W(32), .ACK_LAT(1), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .rst(rst), .wb_adr(adr[0]), .wb_in(din[0]), .wb_out(dout[0]),
    .wb_sel(sel[0]), .wb_we(we[0]), .wb_cyc(cyc[0]), .wb_stb(stb[0]),
    .wb_ack(ack[0]), .wb_stall(stall[0]), .gpioin(gin0), .gpioout(gout0),
    .gpiodir(gdir0), .irq(irq[0]));

  zpu_wb_gpio #(.GPIO_W(32), .ACK_LAT(3), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .rst(rst), .wb_adr(adr[1]), .wb_in(din[1]), .wb_out(dout[1]),
    .wb_sel(sel[1]), .wb_we(we[1]), .wb_cyc(cyc[1]), .wb_stb(stb[1]),
    .wb_ack(ack[1]), .wb_stall(stall[1]), .gpioin(gin1), .gpioout(gout1),
    .gpiodir(gdir1), .irq(irq[1]));

  zpu_wb_gpio #(.GPIO_W(8), .ACK_LAT(4), .SYNC_STAGES(3)) dut2 (
    .clk(clk), .rst(rst), .wb_adr(adr[2]), .wb_in(din[2]), .wb_out(dout[2]),
    .wb_sel(sel[2]), .wb_we(we[2]), .wb_cyc(cyc[2]), .wb_stb(stb[2]),
    .wb_ack(ack[2]), .wb_stall(stall[2]), .gpioin(gin2), .gpioout(gout2),
    .gpiodir(gdir2), .irq(irq[2]));

  // Called at posedge+1; returns at posedge+1 just after the ack cycle ends.
  task automatic wb_xfer(input int d, input logic w, input logic [31:0] a,
                         input logic [31:0] dat, input logic [3:0] s,
                         output logic [31:0] rd, output int lat, output int stall_cyc);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; din[d] = dat; sel[d] = s;
    @(posedge clk); #1;
    stb[d] = 1'b0; we[d] = 1'b0; din[d] = 32'h0;
    lat = 0; stall_cyc = 0; rd = 32'h0;
    for (int i = 1; i <= 8; i++) begin
      if (stall[d]) stall_cyc++;
      if (ack[d]) begin
        lat = i;
        rd = dout[d];
        break;
      end
      @(posedge clk); #1;
    end
    if (lat == 0) begin
      n_vec++; n_err++;
      $display("FAIL ack_timeout dut%0d adr=%h: no ack within 8 cycles", d, a);
    end
    @(posedge clk); #1;
    cyc[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      n_vec++;
      if ({ack[d], stall[d], irq[d]} !== 3'b000) begin
        n_err++;
        $display("FAIL reset_ctl dut%0d got ack/stall/irq=%b want 000", d, {ack[d], stall[d], irq[d]});
      end
      n_vec++;
      if (dout[d] !== 32'h0) begin
        n_err++;
        $display("FAIL reset_out dut%0d got %h want 0", d, dout[d]);
      end
    end
    n_vec++;
    if ({gout0, gdir0, gout1, gdir1, gout2, gdir2} !== '0) begin
      n_err++;
      $display("FAIL reset_gpio got out0=%h dir0=%h out1=%h dir1=%h out2=%h dir2=%h want all 0",
               gout0, gdir0, gout1, gdir1, gout2, gdir2);
    end
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_ack_latency();
    logic [31:0] rd;
    int lat, sc;
    wb_xfer(1, 1'b1, 32'h04, 32'h0000_00FF, 4'hF, rd, lat, sc);
    n_vec++;
    if (lat !== 3) begin n_err++; $display("FAIL lat3_ack got %0d want 3", lat); end
    n_vec++;
    if (sc !== 3) begin n_err++; $display("FAIL lat3_stall got %0d want 3", sc); end
    n_vec++;
    if (gdir1 !== 32'h0000_00FF) begin n_err++; $display("FAIL lat3_dir got %h want 000000ff", gdir1); end
    n_vec++;
    if (stall[1] !== 1'b0) begin n_err++; $display("FAIL lat3_idle_stall got %b want 0", stall[1]); end
  endtask

  task automatic test_set_clr();
    logic [31:0] rd, e;
    int lat, sc;
    wb_xfer(0, 1'b1, 32'h00, 32'h0000_00A5, 4'hF, rd, lat, sc);
    n_vec++;
    if (gout0 !== 32'h0000_00A5) begin n_err++; $display("FAIL data_wr got %h want 000000a5", gout0); end
    n_vec++;
    if (lat !== 1) begin n_err++; $display("FAIL lat1_ack got %0d want 1", lat); end
    wb_xfer(0, 1'b1, 32'h08, 32'h0000_0100, 4'hF, rd, lat, sc);
    n_vec++;
    if (gout0 !== 32'h0000_01A5) begin n_err++; $display("FAIL set_wr got %h want 000001a5", gout0); end
    wb_xfer(0, 1'b1, 32'h0C, 32'h0000_0001, 4'h1, rd, lat, sc);
    n_vec++;
    if (gout0 !== 32'h0000_01A4) begin n_err++; $display("FAIL clr_wr got %h want 000001a4", gout0); end
    wb_xfer(0, 1'b1, 32'h00, 32'h1234_5678, 4'h5, rd, lat, sc);
    n_vec++;
    if (gout0 !== 32'h0034_0178) begin n_err++; $display("FAIL lane_wr got %h want 00340178", gout0); end
    exp_q.push_back(32'h0);
    wb_xfer(0, 1'b0, 32'h08, 32'h0, 4'hF, rd, lat, sc);
    e = exp_q.pop_front();
    n_vec++;
    if (rd !== e) begin n_err++; $display("FAIL set_rd got %h want %h", rd, e); end
    exp_q.push_back(32'h0);
    wb_xfer(0, 1'b0, 32'h0C, 32'h0, 4'hF, rd, lat, sc);
    e = exp_q.pop_front();
    n_vec++;
    if (rd !== e) begin n_err++; $display("FAIL clr_rd got %h want %h", rd, e); end
  endtask

  task automatic test_data_read();
    logic [31:0] rd, e;
    int lat, sc;
    wb_xfer(0, 1'b1, 32'h04, 32'h0000_000F, 4'hF, rd, lat, sc);
    wb_xfer(0, 1'b1, 32'h00, 32'h0000_00FF, 4'hF, rd, lat, sc);
    gin0 = 32'h0000_0030;
    repeat (4) @(posedge clk);
    #1;
    exp_q.push_back(32'h0000_003F);
    wb_xfer(0, 1'b0, 32'h00, 32'h0, 4'hF, rd, lat, sc);
    e = exp_q.pop_front();
    n_vec++;
    if (rd !== e) begin n_err++; $display("FAIL data_rd_mix got %h want %h", rd, e); end
    n_vec++;
    if (gdir0 !== 32'h0000_000F) begin n_err++; $display("FAIL dir_out got %h want 0000000f", gdir0); end
  endtask

  task automatic test_edge();
    logic [31:0] rd, e;
    int lat, sc;
    logic irq_s[5];
    wb_xfer(0, 1'b1, 32'h10, 32'h0000_0001, 4'hF, rd, lat, sc);
    gin0 = 32'h0000_0031;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      irq_s[i] = irq[0];
    end
    n_vec++;
    if (irq_s[3] !== 1'b0) begin n_err++; $display("FAIL irq_early got %b want 0", irq_s[3]); end
    n_vec++;
    if (irq_s[4] !== 1'b1) begin n_err++; $display("FAIL irq_rise got %b want 1", irq_s[4]); end
    exp_q.push_back(32'h1);
    wb_xfer(0, 1'b0, 32'h18, 32'h0, 4'hF, rd, lat, sc);
    e = exp_q.pop_front();
    n_vec++;
    if (rd !== e) begin n_err++; $display("FAIL pend_rd got %h want %h", rd, e); end
    wb_xfer(0, 1'b1, 32'h18, 32'h0000_0001, 4'hF, rd, lat, sc);
    exp_q.push_back(32'h0);
    wb_xfer(0, 1'b0, 32'h18, 32'h0, 4'hF, rd, lat, sc);
    e = exp_q.pop_front();
    n_vec++;
    if (rd !== e) begin n_err++; $display("FAIL pend_w1c got %h want %h", rd, e); end
    n_vec++;
    if (irq[0] !== 1'b0) begin n_err++; $display("FAIL irq_clear got %b want 0", irq[0]); end
    gin0 = 32'h0000_0030;
    repeat (6) @(posedge clk);
    #1;
    // New rise lands on PEND in the same edge as the W1C commit.
    gin0 = 32'h0000_0031;
    @(posedge clk); #1;
    wb_xfer(0, 1'b1, 32'h18, 32'h0000_0001, 4'hF, rd, lat, sc);
    exp_q.push_back(32'h1);
    wb_xfer(0, 1'b0, 32'h18, 32'h0, 4'hF, rd, lat, sc);
    e = exp_q.pop_front();
    n_vec++;
    if (rd !== e) begin n_err++; $display("FAIL pend_coincident got %h want %h", rd, e); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, e, v, m, rise_m, fall_m;
    logic [3:0] s;
    logic [31:0] a;
    int lat, sc;
    rise_m = 32'h1;
    fall_m = 32'h0;
    for (int i = 0; i < 6; i++) begin
      v = $urandom;
      s = 4'($urandom_range(1, 15));
      m = 32'h0;
      for (int l = 0; l < 4; l++) if (s[l]) m[8*l +: 8] = 8'hFF;
      a = (i % 2 == 0) ? 32'h10 : 32'h14;
      if (a == 32'h10) begin
        rise_m = (rise_m & ~m) | (v & m);
        e = rise_m;
      end else begin
        fall_m = (fall_m & ~m) | (v & m);
        e = fall_m;
      end
      wb_xfer(0, 1'b1, a, v, s, rd, lat, sc);
      exp_q.push_back(e);
      wb_xfer(0, 1'b0, a, 32'h0, 4'hF, rd, lat, sc);
      e = exp_q.pop_front();
      n_vec++;
      if (rd !== e) begin n_err++; $display("FAIL b2b_rd[%0d] adr=%h got %h want %h", i, a, rd, e); end
    end
  endtask

  task automatic test_abort_narrow();
    logic [31:0] rd, e;
    int lat, sc, acks;
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 32'h00; din[2] = 32'h55; sel[2] = 4'hF;
    @(posedge clk); #1;
    stb[2] = 1'b0; we[2] = 1'b0;
    @(posedge clk); #1;
    cyc[2] = 1'b0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      if (ack[2]) acks++;
      @(posedge clk); #1;
    end
    n_vec++;
    if (acks !== 0) begin n_err++; $display("FAIL abort_ack got %0d acks want 0", acks); end
    n_vec++;
    if (gout2 !== 8'h00) begin n_err++; $display("FAIL abort_wr got %h want 00", gout2); end
    n_vec++;
    if (stall[2] !== 1'b0) begin n_err++; $display("FAIL abort_idle got %b want 0", stall[2]); end
    wb_xfer(2, 1'b1, 32'h00, 32'hFFFF_FFFF, 4'hF, rd, lat, sc);
    n_vec++;
    if (lat !== 4) begin n_err++; $display("FAIL lat4_ack got %0d want 4", lat); end
    n_vec++;
    if (gout2 !== 8'hFF) begin n_err++; $display("FAIL w8_data got %h want ff", gout2); end
    wb_xfer(2, 1'b1, 32'h04, 32'hFFFF_FFFF, 4'hF, rd, lat, sc);
    n_vec++;
    if (gdir2 !== 8'hFF) begin n_err++; $display("FAIL w8_dir got %h want ff", gdir2); end
    exp_q.push_back(32'h0000_00FF);
    wb_xfer(2, 1'b0, 32'h00, 32'h0, 4'hF, rd, lat, sc);
    e = exp_q.pop_front();
    n_vec++;
    if (rd !== e) begin n_err++; $display("FAIL w8_data_rd got %h want %h", rd, e); end
    exp_q.push_back(32'h0000_00FF);
    wb_xfer(2, 1'b0, 32'hFFFF_FF04, 32'h0, 4'hF, rd, lat, sc);
    e = exp_q.pop_front();
    n_vec++;
    if (rd !== e) begin n_err++; $display("FAIL w8_dir_hiadr got %h want %h", rd, e); end
    wb_xfer(2, 1'b1, 32'h1C, 32'hFFFF_FFFF, 4'hF, rd, lat, sc);
    exp_q.push_back(32'h0);
    wb_xfer(2, 1'b0, 32'h1C, 32'h0, 4'hF, rd, lat, sc);
    e = exp_q.pop_front();
    n_vec++;
    if (rd !== e) begin n_err++; $display("FAIL rsvd_rd got %h want %h", rd, e); end
  endtask

  task automatic test_reset_mid();
    int acks;
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h00; din[1] = 32'hAA; sel[1] = 4'hF;
    @(posedge clk); #1;
    stb[1] = 1'b0; we[1] = 1'b0;
    n_vec++;
    if (stall[1] !== 1'b1) begin n_err++; $display("FAIL rstmid_accept got stall %b want 1", stall[1]); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      if (ack[1]) acks++;
      @(posedge clk); #1;
    end
    cyc[1] = 1'b0;
    n_vec++;
    if (acks !== 0) begin n_err++; $display("FAIL rstmid_ack got %0d acks want 0", acks); end
    n_vec++;
    if (gout1 !== 32'h0) begin n_err++; $display("FAIL rstmid_wr got %h want 0", gout1); end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
      adr[d] = 32'h0; din[d] = 32'h0; sel[d] = 4'h0;
    end
    gin0 = 32'h0; gin1 = 32'h0; gin2 = 8'h0;
    rst = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_ack_latency();
    test_set_clr();
    test_data_read();
    test_edge();
    test_back_to_back();
    test_abort_narrow();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_vec++;
    n_err++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/zpu_wb_gpio.md
ZPU_WB_GPIO -- requirements
Module: zpu_wb_gpio

Interface
REQ-001 SHALL have parameter GPIO_W, default 32, number of GPIO pins (1..32).
REQ-002 SHALL have parameter ACK_LAT, default 1, cycles from request acceptance to ack (1..4).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, input synchroniser depth (2..3).
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous active-high reset
- wb_adr  in  32  byte address; bits [4:2] select register; other bits ignored
- wb_in  in  32  write data
- wb_out  out  32  read data
- wb_sel  in  4  byte-lane enables
- wb_we  in  1  write enable
- wb_cyc  in  1  bus cycle
- wb_stb  in  1  strobe
- wb_ack  out  1  single-cycle acknowledge
- wb_stall  out  1  pipelined stall
- gpioin  in  GPIO_W  asynchronous pin inputs
- gpioout  out  GPIO_W  output register
- gpiodir  out  GPIO_W  direction, 1 = output
- irq  out  1  level interrupt

Function
REQ-006 Register map (word offsets): 0x00 DATA, 0x04 DIR, 0x08 SET, 0x0C CLR, 0x10 RISE_EN, 0x14 FALL_EN, 0x18 PEND, 0x1C reserved.
REQ-007 DATA read SHALL return gpioout for bits with dir=1 and synchronised input for bits with dir=0; DATA write SHALL load gpioout.
REQ-008 SET write SHALL OR into gpioout; CLR write SHALL clear gpioout bits written 1; both SHALL read 0.
REQ-009 PEND SHALL be write-1-to-clear; a pin edge and a W1C of the same bit in the same cycle SHALL leave the bit set.
REQ-010 Reserved offset and bits at or above GPIO_W SHALL read 0 and ignore writes.
REQ-011 Writes SHALL honour wb_sel per byte lane; lanes with wb_sel=0 unchanged.
REQ-012 Request accepted when wb_cyc & wb_stb & !wb_stall; address, data, sel and we captured at acceptance.
REQ-013 FSM states IDLE, WAIT, ACK: IDLE->WAIT on acceptance (ACK_LAT>1) or IDLE->ACK (ACK_LAT=1); WAIT->ACK when latency counter reaches ACK_LAT-1; ACK->IDLE always.
REQ-014 wb_stall SHALL be 1 in WAIT and ACK, 0 in IDLE; exactly one request outstanding.
REQ-015 wb_ack SHALL be high exactly one cycle, ACK_LAT cycles after the acceptance edge.
REQ-016 Read data SHALL reflect register state at acceptance and be valid on wb_out only in the ack cycle; wb_out = 0 otherwise.
REQ-017 Write effect SHALL be visible on outputs the cycle after the ack cycle.
REQ-018 wb_cyc low in WAIT or ACK SHALL abort: no ack, no write, FSM to IDLE next cycle.
REQ-019 Rising edge of synchronised bit with RISE_EN=1, or falling edge with FALL_EN=1, SHALL set PEND bit.
REQ-020 Edge latency: pin change to PEND set SHALL be SYNC_STAGES+1 cycles.
REQ-021 irq SHALL be registered OR of PEND, asserting one cycle after any PEND bit sets.
REQ-022 Edge detection SHALL be suppressed for SYNC_STAGES+1 cycles after reset release.

Reset
REQ-023 On rst: gpioout, gpiodir, RISE_EN, FALL_EN, PEND, sync and edge flops = 0; wb_ack, wb_stall, wb_out, irq = 0; FSM = IDLE; latency counter = 0.
REQ-024 rst mid-transaction SHALL discard the request with no ack and no write.

Structure
REQ-025 Register offsets, FSM state encoding and max widths SHALL live in shared package zpu_wb_pkg.
REQ-026 Synchroniser plus edge detector SHALL be sub-module zpu_gpio_sync, parametrised by GPIO_W and SYNC_STAGES.

Verification
REQ-027 ACK_LAT=3: write DIR=0x000000FF, sel=0xF -> ack exactly 3 cycles after acceptance, stall high 3 cycles, gpiodir=0xFF next cycle.
REQ-028 DATA=0xA5 then SET 0x100, CLR 0x01 with sel=0x1 -> gpioout sequence 0xA5, 0x1A5, 0x1A4.
REQ-029 DIR=0x0F, gpioout=0xFF, gpioin=0x30 -> DATA read returns 0x3F.
REQ-030 RISE_EN=0x1, pin0 0->1 -> PEND=0x1 after SYNC_STAGES+1 cycles, irq high next cycle; W1C 0x1 coincident with new edge -> PEND stays 0x1.
REQ-031 Drop wb_cyc in WAIT (ACK_LAT=4) on write DATA=0x55 -> no ack, gpioout unchanged, next request accepted.
REQ-032 GPIO_W=8: write 0xFFFFFFFF to DATA -> gpioout=0xFF, read upper bits 0.
